// File: rtl/imm_encoder_pkg.sv
// Shared RV32I encoding constants, stage-1 request record and the word packer.
// Imported by the encoder, its range checker and the decoder-side tooling.
package imm_encoder_pkg;

    localparam logic [2:0] FMT_I       = 3'd0;
    localparam logic [2:0] FMT_I_SHAMT = 3'd1;
    localparam logic [2:0] FMT_S       = 3'd2;
    localparam logic [2:0] FMT_B       = 3'd3;
    localparam logic [2:0] FMT_U       = 3'd4;
    localparam logic [2:0] FMT_J       = 3'd5;
    localparam logic [2:0] FMT_R       = 3'd6;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        ok;
    } s1_t;

    // Bit scatter of each format; the caller substitutes the NOP when !ok.
    function automatic logic [31:0] pack_instr(input s1_t r);
        logic [31:0] w;
        w = NOP_INSTR;
        case (r.fmt)
            FMT_I:       w = {r.imm[11:0], r.rs1, r.funct3, r.rd, r.opcode};
            FMT_I_SHAMT: w = {r.funct7, r.imm[4:0], r.rs1, r.funct3, r.rd, r.opcode};
            FMT_S:       w = {r.imm[11:5], r.rs2, r.rs1, r.funct3, r.imm[4:0], r.opcode};
            FMT_B:       w = {r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.funct3,
                              r.imm[4:1], r.imm[11], r.opcode};
            FMT_U:       w = {r.imm[31:12], r.rd, r.opcode};
            FMT_J:       w = {r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12],
                              r.rd, r.opcode};
            FMT_R:       w = {r.funct7, r.rs2, r.rs1, r.funct3, r.rd, r.opcode};
            default:     w = NOP_INSTR;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/imm_range_check.sv
// Combinational representability check of a signed immediate for one format.
// A sign-extended field of N bits means imm[31:N-1] are all equal.
module imm_range_check
    import imm_encoder_pkg::*;
(
    input  logic [2:0]  fmt_i,
    input  logic [31:0] imm_i,
    output logic        ok_o
);

    logic sext12;
    logic sext13;
    logic sext21;

    assign sext12 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
    assign sext13 = (&imm_i[31:12]) | ~(|imm_i[31:12]);
    assign sext21 = (&imm_i[31:20]) | ~(|imm_i[31:20]);

    always_comb begin
        ok_o = 1'b0;
        case (fmt_i)
            FMT_I, FMT_S: ok_o = sext12;
            FMT_I_SHAMT:  ok_o = ~(|imm_i[31:5]);
            FMT_B:        ok_o = sext13 & ~imm_i[0];
            FMT_J:        ok_o = sext21 & ~imm_i[0];
            FMT_U:        ok_o = ~(|imm_i[11:0]);
            FMT_R:        ok_o = 1'b1;
            default:      ok_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage RV32I instruction encoder: stage 1 registers and range-checks the
// request, stage 2 packs the word (or a flagged NOP); saturating statistics.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fmt,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             v1_q,    v1_d;
    logic             v2_q,    v2_d;
    s1_t              s1_q,    s1_d;
    logic [31:0]      instr_q, instr_d;
    logic             err_q,   err_d;
    logic [CNT_W-1:0] enc_q,   enc_d;
    logic [CNT_W-1:0] errc_q,  errc_d;

    logic adv1;
    logic adv2;
    logic ok;
    s1_t  req;

    imm_range_check u_range_check (
        .fmt_i (in_fmt),
        .imm_i (in_imm),
        .ok_o  (ok)
    );

    always_comb begin
        req.fmt    = in_fmt;
        req.opcode = in_opcode;
        req.rd     = in_rd;
        req.rs1    = in_rs1;
        req.rs2    = in_rs2;
        req.funct3 = in_funct3;
        req.funct7 = in_funct7;
        req.imm    = in_imm;
        req.ok     = ok;
    end

    // A stage may load when empty or when the stage after it is draining.
    assign adv2     = ~v2_q | out_ready;
    assign adv1     = ~v1_q | adv2;
    assign in_ready = adv1;

    always_comb begin
        v1_d    = v1_q;
        s1_d    = s1_q;
        v2_d    = v2_q;
        instr_d = instr_q;
        err_d   = err_q;
        enc_d   = enc_q;
        errc_d  = errc_q;

        if (adv1) begin
            v1_d = in_valid;
            if (in_valid) begin
                s1_d = req;
            end
        end

        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                instr_d = s1_q.ok ? pack_instr(s1_q) : NOP_INSTR;
                err_d   = ~s1_q.ok;
            end
        end

        if (v2_q && out_ready) begin
            if (err_q) begin
                if (errc_q != CNT_MAX) errc_d = errc_q + CNT_ONE;
            end else begin
                if (enc_q != CNT_MAX) enc_d = enc_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            s1_q    <= '0;
            v2_q    <= 1'b0;
            instr_q <= '0;
            err_q   <= 1'b0;
            enc_q   <= '0;
            errc_q  <= '0;
        end else begin
            v1_q    <= v1_d;
            s1_q    <= s1_d;
            v2_q    <= v2_d;
            instr_q <= instr_d;
            err_q   <= err_d;
            enc_q   <= enc_d;
            errc_q  <= errc_d;
        end
    end

    assign out_valid = v2_q;
    assign out_instr = instr_q;
    assign out_err   = err_q;
    assign enc_count = enc_q;
    assign err_count = errc_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed and randomized round-trip bench for imm_encoder.
module tb_imm_encoder;
    import imm_encoder_pkg::*;

    localparam int CW = 8;
    localparam logic [CW-1:0] CMAX = '1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid, in_ready, out_valid, out_ready, out_err;
    logic [2:0]    in_fmt, in_funct3;
    logic [6:0]    in_opcode, in_funct7;
    logic [4:0]    in_rd, in_rs1, in_rs2;
    logic [31:0]   in_imm, out_instr;
    logic [CW-1:0] enc_count, err_count;

    always #5 clk = ~clk;

    imm_encoder #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err),
        .enc_count(enc_count), .err_count(err_count)
    );

    typedef struct {
        logic [2:0]  f;
        logic [6:0]  op;
        logic [24:0] regs;   // {f7, rs2, rs1, f3, rd}
        logic [31:0] imm;
        logic        err;
    } req_t;

    logic [32:0]   cap_q[$];
    logic [32:0]   exp_q[$];
    req_t          sent_q[$];
    req_t          cur;
    int            passed = 0;
    int            fails  = 0;
    int            total  = 0;
    logic [CW-1:0] m_enc = '0;
    logic [CW-1:0] m_err = '0;

    // Output words are recorded when a transfer is certain at the next edge.
    always @(negedge clk)
        if (rst_n && out_valid && out_ready) cap_q.push_back({out_err, out_instr});

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] imm);
        in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    endtask

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
        logic acc;
        acc = 1'b0;
        set_req(f, op, rd, rs1, rs2, f3, f7, imm);
        in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) break;
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", acc, 1);
    endtask

    task automatic set_w(input int k);
        set_req(FMT_I, 7'b0010011, 5'(k + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k));
    endtask

    task automatic sat_inc(input logic e);
        if (e) begin
            if (m_err != CMAX) m_err++;
        end else if (m_enc != CMAX) m_enc++;
    endtask

    task automatic drain(input string tag);
        logic [32:0] e, c;
        for (int k = 0; k < 200; k++) begin
            if (cap_q.size() >= exp_q.size()) break;
            tick();
        end
        repeat (4) tick();
        chk({tag, "_count"}, cap_q.size(), exp_q.size());
        while (exp_q.size() > 0 && cap_q.size() > 0) begin
            e = exp_q.pop_front();
            c = cap_q.pop_front();
            chk(tag, c, e);
            sat_inc(e[32]);
        end
        exp_q.delete();
        cap_q.delete();
        chk({tag, "_enc"}, enc_count, m_enc);
        chk({tag, "_errc"}, err_count, m_err);
    endtask

    function automatic logic legal(input logic [2:0] f, input logic [31:0] imm);
        int signed s;
        s = $signed(imm);
        case (f)
            FMT_I, FMT_S: return s >= -2048 && s <= 2047;
            FMT_I_SHAMT:  return imm < 32;
            FMT_B:        return s >= -4096 && s <= 4094 && !imm[0];
            FMT_J:        return s >= -1048576 && s <= 1048574 && !imm[0];
            FMT_U:        return imm[11:0] == 12'd0;
            FMT_R:        return 1'b1;
            default:      return 1'b0;
        endcase
    endfunction

    // CPU-side immediate generator.
    function automatic logic [31:0] dec(input logic [2:0] f, input logic [31:0] w);
        case (f)
            FMT_I:       return {{20{w[31]}}, w[31:20]};
            FMT_I_SHAMT: return {27'd0, w[24:20]};
            FMT_S:       return {{20{w[31]}}, w[31:25], w[11:7]};
            FMT_B:       return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            FMT_U:       return {w[31:12], 12'd0};
            FMT_J:       return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default:     return 32'd0;
        endcase
    endfunction

    task automatic gen_req();
        logic [31:0] r;
        r = $urandom;
        cur.f = 3'($urandom_range(0, 7));
        cur.op = 7'($urandom);
        cur.regs = 25'($urandom);
        if ($urandom_range(0, 3) == 0) cur.imm = r;
        else begin
            case (cur.f)
                FMT_I, FMT_S: cur.imm = {{20{r[11]}}, r[11:0]};
                FMT_I_SHAMT:  cur.imm = {27'd0, r[4:0]};
                FMT_B:        cur.imm = {{19{r[12]}}, r[12:1], 1'b0};
                FMT_J:        cur.imm = {{11{r[20]}}, r[20:1], 1'b0};
                FMT_U:        cur.imm = {r[31:12], 12'd0};
                default:      cur.imm = r;
            endcase
        end
        cur.err = !legal(cur.f, cur.imm);
        set_req(cur.f, cur.op, cur.regs[4:0], cur.regs[12:8], cur.regs[17:13],
                cur.regs[7:5], cur.regs[24:18], cur.imm);
    endtask

    initial begin
        int acc, sent;
        logic rdy;
        logic [32:0] c;
        req_t s;

        in_valid = 1'b0; out_ready = 1'b1;
        set_req(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_enc_count", enc_count, 0);
        chk("rst_err_count", err_count, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // I-type latency: accepted at the next edge, valid one edge later
        set_req(FMT_I, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("i_lat1_valid", out_valid, 0);
        tick();
        chk("i_lat2_valid", out_valid, 1);
        chk("i_word", {out_err, out_instr}, {1'b0, 32'hFFF10093});
        tick();
        chk("i_enc_count", enc_count, 1);
        m_enc = 1;
        cap_q.delete();

        // B-type, including both range edges and an odd offset
        send(FMT_B, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_F000);
        exp_q.push_back({1'b0, 32'h80208063});
        send(FMT_B, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4095);
        exp_q.push_back({1'b1, 32'h00000013});
        send(FMT_B, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4094);
        exp_q.push_back({1'b0, 32'h7E208FE3});
        drain("b");

        // J / U
        send(FMT_J, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        exp_q.push_back({1'b0, 32'h001000EF});
        send(FMT_U, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        exp_q.push_back({1'b0, 32'h123452B7});
        send(FMT_U, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001);
        exp_q.push_back({1'b1, 32'h00000013});
        send(FMT_J, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        exp_q.push_back({1'b1, 32'h00000013});
        drain("ju");

        // S, I_SHAMT, R, I edges, illegal format code
        send(FMT_S, 7'b0100011, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'hFFFF_FFF8);
        exp_q.push_back({1'b0, 32'hFE312C23});
        send(FMT_I_SHAMT, 7'b0010011, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0, 32'd3);
        exp_q.push_back({1'b0, 32'h00309093});
        send(FMT_I_SHAMT, 7'b0010011, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0, 32'd32);
        exp_q.push_back({1'b1, 32'h00000013});
        send(FMT_R, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEADBEEF);
        exp_q.push_back({1'b0, 32'h002081B3});
        send(FMT_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047);
        exp_q.push_back({1'b0, 32'h7FF00093});
        send(FMT_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F7FF);
        exp_q.push_back({1'b1, 32'h00000013});
        send(3'd7, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        exp_q.push_back({1'b1, 32'h00000013});
        drain("misc");

        // Backpressure: 4-word stream into a stalled output
        out_ready = 1'b0;
        acc = 0;
        set_w(0);
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rdy = in_ready;
            if (rdy) acc++;
            tick();
            if (rdy && acc < 4) set_w(acc);
        end
        chk("bp_accepts", acc, 2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_hold", {out_valid, out_err, out_instr}, {2'b10, 32'h00000093});
        out_ready = 1'b1;
        for (int k = 0; k < 20 && acc < 4; k++) begin
            @(negedge clk);
            rdy = in_ready;
            if (rdy) acc++;
            tick();
            if (rdy && acc < 4) set_w(acc);
        end
        in_valid = 1'b0;
        chk("bp_accepts_all", acc, 4);
        exp_q.push_back({1'b0, 32'h00000093});
        exp_q.push_back({1'b0, 32'h00100113});
        exp_q.push_back({1'b0, 32'h00200193});
        exp_q.push_back({1'b0, 32'h00300213});
        drain("bp");

        // Reset with two words in flight
        out_ready = 1'b0;
        send(FMT_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        send(FMT_I, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6);
        chk("rst_pre_full", {out_valid, in_ready}, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_ready", in_ready, 1);
        chk("rst_mid_cnt", {enc_count, err_count}, 0);
        m_enc = '0;
        m_err = '0;
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) tick();
        chk("rst_flushed", cap_q.size(), 0);

        // Saturation: 2^CW + 3 good words
        set_req(FMT_R, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        in_valid = 1'b1;
        sent = 0;
        for (int k = 0; k < 400 && sent < (1 << CW) + 3; k++) begin
            @(negedge clk);
            if (in_ready) sent++;
            tick();
        end
        in_valid = 1'b0;
        repeat (5) tick();
        chk("sat_sent", sent, (1 << CW) + 3);
        chk("sat_enc", enc_count, CMAX);
        chk("sat_err", err_count, 0);
        cap_q.delete();
        m_enc = CMAX;

        // Round trip with random output stalls
        acc = 0;
        gen_req();
        in_valid = 1'b1;
        for (int k = 0; k < 40000 && acc < 10000; k++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            rdy = in_ready;
            if (rdy) begin
                sent_q.push_back(cur);
                acc++;
            end
            tick();
            if (rdy) gen_req();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 200 && cap_q.size() < sent_q.size(); k++) tick();
        repeat (3) tick();
        chk("rt_count", cap_q.size(), sent_q.size());
        while (sent_q.size() > 0 && cap_q.size() > 0) begin
            s = sent_q.pop_front();
            c = cap_q.pop_front();
            if (s.err) chk("rt_illegal", c, {1'b1, 32'h00000013});
            else if (s.f == FMT_R) chk("rt_r", c, {1'b0, s.regs, s.op});
            else chk("rt_imm", {c[32], dec(s.f, c[31:0]), c[6:0]}, {1'b0, s.imm, s.op});
            sat_inc(s.err);
        end
        chk("rt_enc", enc_count, m_enc);
        chk("rt_errc", err_count, m_err);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
